// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand-forwarding controller for the 5-stage core.
// Optional perf counters (o_stallCount, o_fwdCount) when HAZARD_PERF_CNT_EN is defined.
module hazard_fwd_unit #(
    parameter int unsigned XLEN              = 32,
    parameter int unsigned LOAD_STALL_CYCLES = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_ID_valid,
    input  logic [4:0]      i_ID_rs1,
    input  logic [4:0]      i_ID_rs2,
    input  logic [4:0]      i_ID_rd,
    input  logic            i_ID_regWrite,
    input  logic            i_ID_memRead,
    input  logic [XLEN-1:0] i_WB_data,
    input  logic            i_flush,
    input  logic            i_freeze,
    output logic [1:0]      o_fwdRs1,
    output logic [1:0]      o_fwdRs2,
    output logic [XLEN-1:0] o_rdDataSave,
    output logic            o_stall
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]     o_stallCount,
    output logic [31:0]     o_fwdCount
`endif
);

    localparam logic [1:0] NO_FWD      = 2'b00;
    localparam logic [1:0] FWD_MEM     = 2'b01;
    localparam logic [1:0] FWD_WB      = 2'b10;
    localparam logic [1:0] FWD_REG_RDW = 2'b11;

    localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL_CYCLES - 1);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
    } dst_t;

    typedef enum logic [0:0] {StIdle, StStall} state_e;

    // The retired slot's only useful content is its data, which o_rdDataSave already holds.
    dst_t       ex_q, mem_q, wb_q, ex_d;
    logic       ex_mem_read_q, ex_mem_read_d;
    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [1:0] fwd1_d, fwd2_d;
    logic       hazard;
    logic       capture;

    function automatic logic hit(input dst_t s, input logic [4:0] rs);
        return s.valid && s.reg_write && (s.rd == rs);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input dst_t ex, input dst_t mem,
                                           input dst_t wb);
        if (rs == 5'd0)     return NO_FWD;
        if (hit(ex, rs))    return FWD_MEM;
        if (hit(mem, rs))   return FWD_WB;
        if (hit(wb, rs))    return FWD_REG_RDW;
        return NO_FWD;
    endfunction

    always_comb begin
        hazard = i_ID_valid && ex_q.valid && ex_mem_read_q && (ex_q.rd != 5'd0) &&
                 ((ex_q.rd == i_ID_rs1) || (ex_q.rd == i_ID_rs2));
        o_stall = !i_flush && ((state_q == StStall) || hazard);
        capture = !o_stall && !i_flush;
    end

    always_comb begin
        ex_d          = '0;
        ex_mem_read_d = 1'b0;
        fwd1_d        = NO_FWD;
        fwd2_d        = NO_FWD;
        if (capture && i_ID_valid) begin
            ex_d          = '{valid: 1'b1, rd: i_ID_rd, reg_write: i_ID_regWrite};
            ex_mem_read_d = i_ID_memRead;
            fwd1_d        = fwd_sel(i_ID_rs1, ex_q, mem_q, wb_q);
            fwd2_d        = fwd_sel(i_ID_rs2, ex_q, mem_q, wb_q);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (i_flush) begin
            state_d = StIdle;
            cnt_d   = 2'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // A single-bubble configuration never needs the STALL state.
                    if (hazard && (STALL_INIT != 2'd0)) begin
                        state_d = StStall;
                        cnt_d   = STALL_INIT;
                    end
                end
                StStall: begin
                    if (cnt_q <= 2'd1) begin
                        state_d = StIdle;
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ex_q          <= '0;
            ex_mem_read_q <= 1'b0;
            mem_q         <= '0;
            wb_q          <= '0;
            o_fwdRs1      <= NO_FWD;
            o_fwdRs2      <= NO_FWD;
            o_rdDataSave  <= '0;
            state_q       <= StIdle;
            cnt_q         <= 2'd0;
        end else if (!i_freeze) begin
            ex_q          <= ex_d;
            ex_mem_read_q <= ex_mem_read_d;
            mem_q         <= ex_q;
            wb_q          <= mem_q;
            o_fwdRs1      <= fwd1_d;
            o_fwdRs2      <= fwd2_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            if (wb_q.valid && wb_q.reg_write && (wb_q.rd != 5'd0)) begin
                o_rdDataSave <= i_WB_data;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stallCount <= '0;
            o_fwdCount   <= '0;
        end else if (!i_freeze) begin
            if (o_stall) begin
                o_stallCount <= o_stallCount + 32'd1;
            end
            if ((fwd1_d != NO_FWD) || (fwd2_d != NO_FWD)) begin
                o_fwdCount <= o_fwdCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: one instance with 1 load bubble, one with 3.
// Honours HAZARD_PERF_CNT_EN when the design is built with it.
module tb_hazard_fwd_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_rw, id_mr;
    logic [31:0] wb_data;
    logic        flush, freeze;

    logic [1:0]  f1_a, f2_a, f1_b, f2_b;
    logic [31:0] data_a, data_b;
    logic        stall_a, stall_b;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] scnt_a, fcnt_a, scnt_b, fcnt_b;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        v;
        logic [4:0]  rs1, rs2, rd;
        logic        rw, mr, fl, fz;
        logic [31:0] wb;
        logic [1:0]  f1, f2;
        logic        st;
        logic [31:0] d;
    } row_t;

    // Observed per step: {fwdRs1, fwdRs2, stall before the edge, rdDataSave after the edge}
    logic [36:0] obs_a, obs_b;
    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    hazard_fwd_unit #(.XLEN(32), .LOAD_STALL_CYCLES(1)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_ID_valid(id_valid), .i_ID_rs1(id_rs1),
        .i_ID_rs2(id_rs2), .i_ID_rd(id_rd), .i_ID_regWrite(id_rw), .i_ID_memRead(id_mr),
        .i_WB_data(wb_data), .i_flush(flush), .i_freeze(freeze), .o_fwdRs1(f1_a),
        .o_fwdRs2(f2_a), .o_rdDataSave(data_a), .o_stall(stall_a)
`ifdef HAZARD_PERF_CNT_EN
        , .o_stallCount(scnt_a), .o_fwdCount(fcnt_a)
`endif
    );

    hazard_fwd_unit #(.XLEN(32), .LOAD_STALL_CYCLES(3)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_ID_valid(id_valid), .i_ID_rs1(id_rs1),
        .i_ID_rs2(id_rs2), .i_ID_rd(id_rd), .i_ID_regWrite(id_rw), .i_ID_memRead(id_mr),
        .i_WB_data(wb_data), .i_flush(flush), .i_freeze(freeze), .o_fwdRs1(f1_b),
        .o_fwdRs2(f2_b), .o_rdDataSave(data_b), .o_stall(stall_b)
`ifdef HAZARD_PERF_CNT_EN
        , .o_stallCount(scnt_b), .o_fwdCount(fcnt_b)
`endif
    );

    function automatic row_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic rw, input logic mr,
                                input logic fl, input logic fz, input logic [31:0] wb,
                                input logic [1:0] f1, input logic [1:0] f2, input logic st,
                                input logic [31:0] d);
        row_t r;
        r = '{v: v, rs1: rs1, rs2: rs2, rd: rd, rw: rw, mr: mr, fl: fl, fz: fz, wb: wb,
              f1: f1, f2: f2, st: st, d: d};
        return r;
    endfunction

    task automatic set_idle();
        id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
        id_rw = 1'b0; id_mr = 1'b0; wb_data = 32'h0; flush = 1'b0; freeze = 1'b0;
    endtask

    // Drive one cycle of stimulus: stall sampled before the edge, registers #1 after it.
    task automatic cyc(input row_t r);
        logic sa, sb;
        id_valid = r.v; id_rs1 = r.rs1; id_rs2 = r.rs2; id_rd = r.rd;
        id_rw = r.rw; id_mr = r.mr; flush = r.fl; freeze = r.fz; wb_data = r.wb;
        #1;
        sa = stall_a;
        sb = stall_b;
        @(posedge clk);
        #1;
        obs_a = {f1_a, f2_a, sa, data_a};
        obs_b = {f1_b, f2_b, sb, data_b};
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({f1_a, f2_a, stall_a, data_a} !== 37'h0) begin
            errors++;
            $display("FAIL reset_a: got fwd1=%b fwd2=%b stall=%b save=%h, expected all zero",
                     f1_a, f2_a, stall_a, data_a);
        end
        checks++;
        if ({f1_b, f2_b, stall_b, data_b} !== 37'h0) begin
            errors++;
            $display("FAIL reset_b: got fwd1=%b fwd2=%b stall=%b save=%h, expected all zero",
                     f1_b, f2_b, stall_b, data_b);
        end
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        if ({scnt_a, fcnt_a, scnt_b, fcnt_b} !== 128'h0) begin
            errors++;
            $display("FAIL reset_perf: got %h %h %h %h, expected zero",
                     scnt_a, fcnt_a, scnt_b, fcnt_b);
        end
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        row_t rows[$];
        logic [36:0] e;
        do_reset();
        rows.push_back(mk(1, 1, 2, 5, 1, 0, 0, 0, 32'h0, 2'b00, 2'b00, 0, 32'h0));
        rows.push_back(mk(1, 5, 6, 8, 1, 0, 0, 0, 32'h0, 2'b01, 2'b00, 0, 32'h0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 2'b00, 2'b00, 0, 32'h0));
        foreach (rows[i]) begin
            exp_q.push_back({rows[i].f1, rows[i].f2, rows[i].st, rows[i].d});
            cyc(rows[i]);
            e = exp_q.pop_front();
            checks++;
            if (obs_a !== e) begin
                errors++;
                $display("FAIL back_to_back step %0d: got %b_%b_%b_%h expected %b_%b_%b_%h", i,
                         obs_a[36:35], obs_a[34:33], obs_a[32], obs_a[31:0],
                         e[36:35], e[34:33], e[32], e[31:0]);
            end
        end
    endtask

    task automatic test_distance();
        row_t rows[$];
        logic [36:0] e;
        do_reset();
        rows.push_back(mk(1, 1, 2, 7, 1, 0, 0, 0, 32'h0A0A0A01, 2'b00, 2'b00, 0, 32'h0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0A0A0A02, 2'b00, 2'b00, 0, 32'h0));
        rows.push_back(mk(1, 1, 7, 10, 1, 0, 0, 0, 32'h0A0A0A03, 2'b00, 2'b10, 0, 32'h0));
        rows.push_back(mk(1, 3, 4, 7, 1, 0, 0, 0, 32'h11111111, 2'b00, 2'b00, 0, 32'h11111111));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h33333333, 2'b00, 2'b00, 0, 32'h11111111));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h22222222, 2'b00, 2'b00, 0, 32'h22222222));
        rows.push_back(mk(1, 0, 7, 11, 1, 0, 0, 0, 32'hDEADBEEF, 2'b00, 2'b11, 0, 32'hDEADBEEF));
        foreach (rows[i]) begin
            exp_q.push_back({rows[i].f1, rows[i].f2, rows[i].st, rows[i].d});
            cyc(rows[i]);
            e = exp_q.pop_front();
            checks++;
            if (obs_a !== e) begin
                errors++;
                $display("FAIL distance step %0d: got %b_%b_%b_%h expected %b_%b_%b_%h", i,
                         obs_a[36:35], obs_a[34:33], obs_a[32], obs_a[31:0],
                         e[36:35], e[34:33], e[32], e[31:0]);
            end
        end
    endtask

    task automatic test_load_use1();
        row_t rows[$];
        logic [36:0] e;
        do_reset();
        rows.push_back(mk(1, 1, 0, 3, 1, 1, 0, 0, 32'h0, 2'b00, 2'b00, 0, 32'h0));
        rows.push_back(mk(1, 3, 4, 12, 1, 0, 0, 0, 32'h0, 2'b00, 2'b00, 1, 32'h0));
        rows.push_back(mk(1, 3, 4, 12, 1, 0, 0, 0, 32'h0, 2'b10, 2'b00, 0, 32'h0));
        rows.push_back(mk(1, 12, 0, 13, 1, 0, 0, 0, 32'h0, 2'b01, 2'b00, 0, 32'h0));
        foreach (rows[i]) begin
            exp_q.push_back({rows[i].f1, rows[i].f2, rows[i].st, rows[i].d});
            cyc(rows[i]);
            e = exp_q.pop_front();
            checks++;
            if (obs_a !== e) begin
                errors++;
                $display("FAIL load_use1 step %0d: got %b_%b_%b_%h expected %b_%b_%b_%h", i,
                         obs_a[36:35], obs_a[34:33], obs_a[32], obs_a[31:0],
                         e[36:35], e[34:33], e[32], e[31:0]);
            end
        end
    endtask

    task automatic test_load_use3();
        row_t rows[$];
        logic [36:0] e;
        do_reset();
        rows.push_back(mk(1, 1, 0, 3, 1, 1, 0, 0, 32'h0, 2'b00, 2'b00, 0, 32'h0));
        rows.push_back(mk(1, 3, 4, 12, 1, 0, 0, 0, 32'h0, 2'b00, 2'b00, 1, 32'h0));
        rows.push_back(mk(1, 3, 4, 12, 1, 0, 0, 0, 32'h0, 2'b00, 2'b00, 1, 32'h0));
        rows.push_back(mk(1, 3, 4, 12, 1, 0, 0, 0, 32'h0, 2'b00, 2'b00, 1, 32'h0));
        rows.push_back(mk(1, 3, 4, 12, 1, 0, 0, 0, 32'h0, 2'b00, 2'b00, 0, 32'h0));
        rows.push_back(mk(1, 12, 0, 13, 1, 0, 0, 0, 32'h0, 2'b01, 2'b00, 0, 32'h0));
        foreach (rows[i]) begin
            exp_q.push_back({rows[i].f1, rows[i].f2, rows[i].st, rows[i].d});
            cyc(rows[i]);
            e = exp_q.pop_front();
            checks++;
            if (obs_b !== e) begin
                errors++;
                $display("FAIL load_use3 step %0d: got %b_%b_%b_%h expected %b_%b_%b_%h", i,
                         obs_b[36:35], obs_b[34:33], obs_b[32], obs_b[31:0],
                         e[36:35], e[34:33], e[32], e[31:0]);
            end
        end
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        if ({scnt_b, fcnt_b} !== {32'd3, 32'd1}) begin
            errors++;
            $display("FAIL load_use3_perf: got stallCount=%0d fwdCount=%0d, expected 3 and 1",
                     scnt_b, fcnt_b);
        end
`endif
    endtask

    task automatic test_x0_priority();
        row_t rows[$];
        logic [36:0] e;
        do_reset();
        rows.push_back(mk(1, 1, 2, 0, 1, 0, 0, 0, 32'h55555555, 2'b00, 2'b00, 0, 32'h0));
        rows.push_back(mk(1, 0, 0, 14, 1, 0, 0, 0, 32'h55555555, 2'b00, 2'b00, 0, 32'h0));
        rows.push_back(mk(1, 1, 2, 9, 1, 0, 0, 0, 32'h55555555, 2'b00, 2'b00, 0, 32'h0));
        rows.push_back(mk(1, 3, 3, 9, 1, 0, 0, 0, 32'h55555555, 2'b00, 2'b00, 0, 32'h0));
        rows.push_back(mk(1, 9, 9, 15, 1, 0, 0, 0, 32'h55555555, 2'b01, 2'b01, 0,
                          32'h55555555));
        foreach (rows[i]) begin
            exp_q.push_back({rows[i].f1, rows[i].f2, rows[i].st, rows[i].d});
            cyc(rows[i]);
            e = exp_q.pop_front();
            checks++;
            if (obs_a !== e) begin
                errors++;
                $display("FAIL x0_priority step %0d: got %b_%b_%b_%h expected %b_%b_%b_%h", i,
                         obs_a[36:35], obs_a[34:33], obs_a[32], obs_a[31:0],
                         e[36:35], e[34:33], e[32], e[31:0]);
            end
        end
    endtask

    task automatic test_flush_stall();
        row_t rows[$];
        logic [36:0] e;
        do_reset();
        rows.push_back(mk(1, 1, 0, 3, 1, 1, 0, 0, 32'h0, 2'b00, 2'b00, 0, 32'h0));
        rows.push_back(mk(1, 3, 4, 12, 1, 0, 0, 0, 32'h0, 2'b00, 2'b00, 1, 32'h0));
        rows.push_back(mk(1, 3, 4, 12, 1, 0, 1, 0, 32'h0, 2'b00, 2'b00, 0, 32'h0));
        rows.push_back(mk(1, 3, 4, 12, 1, 0, 0, 0, 32'h0, 2'b11, 2'b00, 0, 32'h0));
        foreach (rows[i]) begin
            exp_q.push_back({rows[i].f1, rows[i].f2, rows[i].st, rows[i].d});
            cyc(rows[i]);
            e = exp_q.pop_front();
            checks++;
            if (obs_b !== e) begin
                errors++;
                $display("FAIL flush_stall step %0d: got %b_%b_%b_%h expected %b_%b_%b_%h", i,
                         obs_b[36:35], obs_b[34:33], obs_b[32], obs_b[31:0],
                         e[36:35], e[34:33], e[32], e[31:0]);
            end
        end
    endtask

    task automatic test_freeze();
        row_t rows[$];
        logic [36:0] e;
        do_reset();
        rows.push_back(mk(1, 1, 0, 3, 1, 1, 0, 0, 32'h0, 2'b00, 2'b00, 0, 32'h0));
        rows.push_back(mk(1, 3, 4, 12, 1, 0, 0, 0, 32'h0, 2'b00, 2'b00, 1, 32'h0));
        rows.push_back(mk(1, 3, 4, 12, 1, 0, 0, 1, 32'h0, 2'b00, 2'b00, 1, 32'h0));
        rows.push_back(mk(1, 3, 4, 12, 1, 0, 0, 1, 32'h0, 2'b00, 2'b00, 1, 32'h0));
        rows.push_back(mk(1, 3, 4, 12, 1, 0, 0, 0, 32'h0, 2'b00, 2'b00, 1, 32'h0));
        rows.push_back(mk(1, 3, 4, 12, 1, 0, 0, 0, 32'h0, 2'b00, 2'b00, 1, 32'h0));
        rows.push_back(mk(1, 3, 4, 12, 1, 0, 0, 0, 32'h0, 2'b00, 2'b00, 0, 32'h0));
        rows.push_back(mk(1, 12, 0, 13, 1, 0, 0, 0, 32'h0, 2'b01, 2'b00, 0, 32'h0));
        foreach (rows[i]) begin
            exp_q.push_back({rows[i].f1, rows[i].f2, rows[i].st, rows[i].d});
            cyc(rows[i]);
            e = exp_q.pop_front();
            checks++;
            if (obs_b !== e) begin
                errors++;
                $display("FAIL freeze step %0d: got %b_%b_%b_%h expected %b_%b_%b_%h", i,
                         obs_b[36:35], obs_b[34:33], obs_b[32], obs_b[31:0],
                         e[36:35], e[34:33], e[32], e[31:0]);
            end
        end
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        if (scnt_b !== 32'd3) begin
            errors++;
            $display("FAIL freeze_perf: got stallCount=%0d, expected 3", scnt_b);
        end
`endif
    endtask

    task automatic test_reset_mid_stall();
        row_t rows[$];
        logic [36:0] e;
        do_reset();
        rows.push_back(mk(1, 1, 2, 5, 1, 0, 0, 0, 32'h0, 2'b00, 2'b00, 0, 32'h0));
        rows.push_back(mk(1, 5, 0, 3, 1, 1, 0, 0, 32'h0, 2'b01, 2'b00, 0, 32'h0));
        rows.push_back(mk(1, 3, 4, 12, 1, 0, 0, 0, 32'h0, 2'b00, 2'b00, 1, 32'h0));
        rows.push_back(mk(1, 3, 4, 12, 1, 0, 0, 0, 32'h77777777, 2'b00, 2'b00, 1,
                          32'h77777777));
        foreach (rows[i]) begin
            exp_q.push_back({rows[i].f1, rows[i].f2, rows[i].st, rows[i].d});
            cyc(rows[i]);
            e = exp_q.pop_front();
            checks++;
            if (obs_b !== e) begin
                errors++;
                $display("FAIL reset_mid_stall step %0d: got %b_%b_%b_%h expected %b_%b_%b_%h",
                         i, obs_b[36:35], obs_b[34:33], obs_b[32], obs_b[31:0],
                         e[36:35], e[34:33], e[32], e[31:0]);
            end
        end
        #2;
        checks++;
        if (stall_b !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_stall: got stall=%b, expected 1", stall_b);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({f1_b, f2_b, stall_b, data_b} !== 37'h0) begin
            errors++;
            $display("FAIL async_reset: got fwd1=%b fwd2=%b stall=%b save=%h, expected zero",
                     f1_b, f2_b, stall_b, data_b);
        end
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        if (scnt_b !== 32'd0) begin
            errors++;
            $display("FAIL async_reset_perf: got stallCount=%0d, expected 0", scnt_b);
        end
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_distance();
        test_load_use1();
        test_load_use3();
        test_x0_priority();
        test_flush_stall();
        test_freeze();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, expected finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
